// File: rtl/bip_control_if.sv
// Bus between the bip_control sequencer and the program memory / datapath.
// master = control unit, slave = program memory + ACC/arith/data-RAM datapath.
interface bip_control_if #(
  parameter int N_BUS  = 16,
  parameter int N_ADDR = 11,
  parameter int N_CNT  = 16
);
  logic              i_start;
  logic [N_BUS-1:0]  i_INSTR;
  logic [N_ADDR-1:0] o_PROG_ADDR;
  logic [N_ADDR-1:0] o_OPERAND;
  logic [1:0]        o_SEL_A;
  logic              o_SEL_B;
  logic              o_OP;
  logic              o_WR_ACC;
  logic              o_WR_RAM;
  logic              o_RD_RAM;
  logic              o_BUSY;
  logic              o_HALT;
  logic [N_CNT-1:0]  o_INSTR_CNT;

  modport master (
    input  i_start, i_INSTR,
    output o_PROG_ADDR, o_OPERAND, o_SEL_A, o_SEL_B, o_OP,
           o_WR_ACC, o_WR_RAM, o_RD_RAM, o_BUSY, o_HALT, o_INSTR_CNT
  );

  modport slave (
    output i_start, i_INSTR,
    input  o_PROG_ADDR, o_OPERAND, o_SEL_A, o_SEL_B, o_OP,
           o_WR_ACC, o_WR_RAM, o_RD_RAM, o_BUSY, o_HALT, o_INSTR_CNT
  );
endinterface

// File: rtl/bip_control.sv
// Control unit of the accumulator CPU: fetch/execute sequencer, instruction
// decoder, program counter and saturating retired-instruction counter.
// One instruction every two cycles (FETCH then EXEC). All datapath strobes
// are decoded combinationally from the program-memory word during EXEC only,
// so an asynchronous reset drops them immediately (no partial write).
module bip_control #(
  parameter int N_BUS    = 16,
  parameter int N_OPCODE = 5,
  parameter int N_ADDR   = N_BUS - N_OPCODE,
  parameter int N_CNT    = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  bip_control_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [N_OPCODE-1:0] OP_HLT  = N_OPCODE'(0);
  localparam logic [N_OPCODE-1:0] OP_STO  = N_OPCODE'(1);
  localparam logic [N_OPCODE-1:0] OP_LD   = N_OPCODE'(2);
  localparam logic [N_OPCODE-1:0] OP_LDI  = N_OPCODE'(3);
  localparam logic [N_OPCODE-1:0] OP_ADD  = N_OPCODE'(4);
  localparam logic [N_OPCODE-1:0] OP_ADDI = N_OPCODE'(5);
  localparam logic [N_OPCODE-1:0] OP_SUB  = N_OPCODE'(6);
  localparam logic [N_OPCODE-1:0] OP_SUBI = N_OPCODE'(7);

  // ACC source mux encodings
  localparam logic [1:0] SEL_A_RAM   = 2'd0;
  localparam logic [1:0] SEL_A_IMM   = 2'd1;
  localparam logic [1:0] SEL_A_ARITH = 2'd2;

  // arith B operand encodings
  localparam logic SEL_B_RAM = 1'b0;
  localparam logic SEL_B_IMM = 1'b1;

  // arith op encodings
  localparam logic OP_PLUS  = 1'b0;
  localparam logic OP_MINUS = 1'b1;

  state_t            state_reg;
  state_t            state_next;
  logic [N_ADDR-1:0] pc_reg;
  logic [N_CNT-1:0]  cnt_reg;

  logic [N_OPCODE-1:0] opcode;
  logic [N_ADDR-1:0]   operand_field;
  logic                is_hlt;
  logic                cnt_full;

  logic [N_ADDR-1:0] operand;
  logic [1:0]        sel_a;
  logic              sel_b;
  logic              op;
  logic              wr_acc;
  logic              wr_ram;
  logic              rd_ram;
  logic              busy;
  logic              halt;

  assign opcode        = bus.i_INSTR[N_BUS-1 -: N_OPCODE];
  assign operand_field = bus.i_INSTR[N_ADDR-1:0];
  assign is_hlt        = (opcode == OP_HLT);
  assign cnt_full      = (cnt_reg == {N_CNT{1'b1}});

  // State register; reset aborts any instruction in flight
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; i_start only matters when not running
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (bus.i_start) state_next = S_FETCH;
      S_FETCH: state_next = S_EXEC;
      S_EXEC:  state_next = is_hlt ? S_HALT : S_FETCH;
      S_HALT:  if (bus.i_start) state_next = S_FETCH;
      default: state_next = S_IDLE;
    endcase
  end

  // PC and retired-instruction counter; HLT retires but leaves PC on itself
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pc_reg  <= '0;
      cnt_reg <= '0;
    end else begin
      case (state_reg)
        S_EXEC: begin
          if (!is_hlt) begin
            pc_reg <= pc_reg + N_ADDR'(1);
          end
          if (!cnt_full) begin
            cnt_reg <= cnt_reg + N_CNT'(1);
          end
        end
        S_IDLE, S_HALT: begin
          if (bus.i_start) begin
            pc_reg  <= '0;
            cnt_reg <= '0;
          end
        end
        default: begin
          pc_reg  <= pc_reg;
          cnt_reg <= cnt_reg;
        end
      endcase
    end
  end

  // Output decode: strobes live for the single EXEC cycle only
  always_comb begin
    operand = '0;
    sel_a   = SEL_A_RAM;
    sel_b   = SEL_B_RAM;
    op      = OP_PLUS;
    wr_acc  = 1'b0;
    wr_ram  = 1'b0;
    rd_ram  = 1'b0;
    busy    = (state_reg == S_FETCH) || (state_reg == S_EXEC);
    halt    = (state_reg == S_HALT);
    if (state_reg == S_EXEC) begin
      operand = operand_field;
      case (opcode)
        OP_STO: begin
          wr_ram = 1'b1;
        end
        OP_LD: begin
          rd_ram = 1'b1;
          sel_a  = SEL_A_RAM;
          wr_acc = 1'b1;
        end
        OP_LDI: begin
          sel_a  = SEL_A_IMM;
          wr_acc = 1'b1;
        end
        OP_ADD: begin
          rd_ram = 1'b1;
          sel_b  = SEL_B_RAM;
          op     = OP_PLUS;
          sel_a  = SEL_A_ARITH;
          wr_acc = 1'b1;
        end
        OP_ADDI: begin
          sel_b  = SEL_B_IMM;
          op     = OP_PLUS;
          sel_a  = SEL_A_ARITH;
          wr_acc = 1'b1;
        end
        OP_SUB: begin
          rd_ram = 1'b1;
          sel_b  = SEL_B_RAM;
          op     = OP_MINUS;
          sel_a  = SEL_A_ARITH;
          wr_acc = 1'b1;
        end
        OP_SUBI: begin
          sel_b  = SEL_B_IMM;
          op     = OP_MINUS;
          sel_a  = SEL_A_ARITH;
          wr_acc = 1'b1;
        end
        default: begin
          // HLT and undefined opcodes drive no strobes
          wr_acc = 1'b0;
        end
      endcase
    end
  end

  assign bus.o_PROG_ADDR = pc_reg;
  assign bus.o_INSTR_CNT = cnt_reg;
  assign bus.o_OPERAND   = operand;
  assign bus.o_SEL_A     = sel_a;
  assign bus.o_SEL_B     = sel_b;
  assign bus.o_OP        = op;
  assign bus.o_WR_ACC    = wr_acc;
  assign bus.o_WR_RAM    = wr_ram;
  assign bus.o_RD_RAM    = rd_ram;
  assign bus.o_BUSY      = busy;
  assign bus.o_HALT      = halt;

endmodule

// File: tb/tb_bip_control.sv
// Directed bench for bip_control: a full-width instance with a small
// ACC/data-RAM model, and a narrow instance (N_ADDR=3, N_CNT=2) for PC wrap
// and counter saturation.
module tb_bip_control;

  localparam logic [4:0] HLT  = 5'd0;
  localparam logic [4:0] STO  = 5'd1;
  localparam logic [4:0] LD   = 5'd2;
  localparam logic [4:0] LDI  = 5'd3;
  localparam logic [4:0] ADD  = 5'd4;
  localparam logic [4:0] ADDI = 5'd5;
  localparam logic [4:0] SUB  = 5'd6;
  localparam logic [4:0] SUBI = 5'd7;
  localparam logic [4:0] UND  = 5'd31;

  // strobe vector {SEL_A, SEL_B, OP, WR_ACC, WR_RAM, RD_RAM}
  localparam logic [6:0] V_NONE = 7'b0000000;
  localparam logic [6:0] V_STO  = 7'b0000010;
  localparam logic [6:0] V_LD   = 7'b0000101;
  localparam logic [6:0] V_LDI  = 7'b0100100;
  localparam logic [6:0] V_ADD  = 7'b1000101;
  localparam logic [6:0] V_ADDI = 7'b1010100;
  localparam logic [6:0] V_SUB  = 7'b1001101;
  localparam logic [6:0] V_SUBI = 7'b1011100;

  logic i_clk = 1'b0;
  logic i_reset;
  int   total = 0;
  int   bad   = 0;

  always #5 i_clk = ~i_clk;

  bip_control_if #(.N_BUS(16), .N_ADDR(11), .N_CNT(16)) bus_a ();
  bip_control_if #(.N_BUS(8),  .N_ADDR(3),  .N_CNT(2))  bus_b ();

  bip_control #(.N_BUS(16), .N_OPCODE(5), .N_ADDR(11), .N_CNT(16)) dut_a (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus_a)
  );

  bip_control #(.N_BUS(8), .N_OPCODE(5), .N_ADDR(3), .N_CNT(2)) dut_b (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus_b)
  );

  logic [15:0] mem_a [0:2047];
  logic [7:0]  mem_b [0:7];
  logic [15:0] ram   [0:2047];
  logic [15:0] acc = 16'd0;
  logic [15:0] imm_a;
  logic [15:0] b_a;
  logic [6:0]  strb_a;
  logic [6:0]  strb_b;
  logic [6:0]  exp_strb [0:8];

  assign strb_a = {bus_a.o_SEL_A, bus_a.o_SEL_B, bus_a.o_OP,
                   bus_a.o_WR_ACC, bus_a.o_WR_RAM, bus_a.o_RD_RAM};
  assign strb_b = {bus_b.o_SEL_A, bus_b.o_SEL_B, bus_b.o_OP,
                   bus_b.o_WR_ACC, bus_b.o_WR_RAM, bus_b.o_RD_RAM};

  // synchronous program memories: data valid one cycle after address
  always @(posedge i_clk) begin
    bus_a.i_INSTR <= mem_a[bus_a.o_PROG_ADDR];
    bus_b.i_INSTR <= mem_b[bus_b.o_PROG_ADDR];
  end

  // ACC / arithmetic / data-RAM datapath driven by the control strobes
  assign imm_a = {{5{bus_a.o_OPERAND[10]}}, bus_a.o_OPERAND};
  assign b_a   = bus_a.o_SEL_B ? imm_a : ram[bus_a.o_OPERAND];
  always @(posedge i_clk) begin
    if (bus_a.o_WR_ACC) begin
      case (bus_a.o_SEL_A)
        2'd0:    acc <= ram[bus_a.o_OPERAND];
        2'd1:    acc <= imm_a;
        2'd2:    acc <= bus_a.o_OP ? (acc - b_a) : (acc + b_a);
        default: acc <= 16'hxxxx;
      endcase
    end
    if (bus_a.o_WR_RAM) ram[bus_a.o_OPERAND] <= acc;
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ins(input logic [4:0] opc, input logic [10:0] a);
    return {opc, a};
  endfunction

  initial begin
    i_reset       = 1'b1;
    bus_a.i_start = 1'b0;
    bus_b.i_start = 1'b0;
    for (int i = 0; i < 2048; i++) mem_a[i] = ins(UND, 11'd0);
    for (int i = 0; i < 8; i++) mem_b[i] = 8'hF8;

    // ---------------- reset state ----------------
    tick();
    tick();
    #2 i_reset = 1'b0;
    tick();
    check("rst_busy_a",  32'(bus_a.o_BUSY), 32'd0);
    check("rst_halt_a",  32'(bus_a.o_HALT), 32'd0);
    check("rst_pc_a",    32'(bus_a.o_PROG_ADDR), 32'd0);
    check("rst_cnt_a",   32'(bus_a.o_INSTR_CNT), 32'd0);
    check("rst_strb_a",  32'(strb_a), 32'(V_NONE));
    check("rst_opnd_a",  32'(bus_a.o_OPERAND), 32'd0);
    check("rst_busy_b",  32'(bus_b.o_BUSY), 32'd0);
    check("rst_pc_b",    32'(bus_b.o_PROG_ADDR), 32'd0);
    tick();
    check("idle_hold",   32'(bus_a.o_BUSY), 32'd0);

    // ---------------- program LDI 5; ADDI 3; STO 10; SUB 10; HLT ----------------
    mem_a[0] = ins(LDI, 11'd5);
    mem_a[1] = ins(ADDI, 11'd3);
    mem_a[2] = ins(STO, 11'd10);
    mem_a[3] = ins(SUB, 11'd10);
    mem_a[4] = ins(HLT, 11'd0);
    bus_a.i_start = 1'b1;
    tick();
    bus_a.i_start = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      case (k)
        1: begin
          check("prog_fetch_strb", 32'(strb_a), 32'(V_NONE));
          check("prog_fetch_busy", 32'(bus_a.o_BUSY), 32'd1);
          check("prog_fetch_pc",   32'(bus_a.o_PROG_ADDR), 32'd0);
        end
        2: begin
          check("prog_ldi_strb", 32'(strb_a), 32'(V_LDI));
          check("prog_ldi_opnd", 32'(bus_a.o_OPERAND), 32'd5);
        end
        7: begin
          check("prog_acc8",  32'(acc), 32'd8);
          check("prog_ram10", 32'(ram[10]), 32'd8);
        end
        10: check("prog_halt_early", 32'(bus_a.o_HALT), 32'd0);
        11: begin
          check("prog_halt",  32'(bus_a.o_HALT), 32'd1);
          check("prog_busy",  32'(bus_a.o_BUSY), 32'd0);
          check("prog_pc",    32'(bus_a.o_PROG_ADDR), 32'd4);
          check("prog_cnt",   32'(bus_a.o_INSTR_CNT), 32'd5);
          check("prog_acc0",  32'(acc), 32'd0);
        end
        default: ;
      endcase
      if (k < 11) tick();
    end
    tick();
    tick();
    check("halt_hold",     32'(bus_a.o_HALT), 32'd1);
    check("halt_hold_pc",  32'(bus_a.o_PROG_ADDR), 32'd4);
    check("halt_hold_cnt", 32'(bus_a.o_INSTR_CNT), 32'd5);

    // ---------------- strobe table, undefined opcode, start ignored while busy ----------------
    mem_a[0] = ins(STO,  11'd12);
    mem_a[1] = ins(LD,   11'd12);
    mem_a[2] = ins(LDI,  11'd12);
    mem_a[3] = ins(ADD,  11'd12);
    mem_a[4] = ins(ADDI, 11'd12);
    mem_a[5] = ins(SUB,  11'd12);
    mem_a[6] = ins(SUBI, 11'd12);
    mem_a[7] = ins(UND,  11'd12);
    mem_a[8] = ins(HLT,  11'd12);
    exp_strb[0] = V_STO;
    exp_strb[1] = V_LD;
    exp_strb[2] = V_LDI;
    exp_strb[3] = V_ADD;
    exp_strb[4] = V_ADDI;
    exp_strb[5] = V_SUB;
    exp_strb[6] = V_SUBI;
    exp_strb[7] = V_NONE;
    exp_strb[8] = V_NONE;
    bus_a.i_start = 1'b1;
    tick();
    bus_a.i_start = 1'b0;
    for (int k = 1; k <= 19; k++) begin
      if (k == 3) bus_a.i_start = 1'b1;
      if (k == 5) bus_a.i_start = 1'b0;
      if (k == 19) begin
        check("strb_halt",     32'(bus_a.o_HALT), 32'd1);
        check("strb_halt_pc",  32'(bus_a.o_PROG_ADDR), 32'd8);
        check("strb_halt_cnt", 32'(bus_a.o_INSTR_CNT), 32'd9);
      end else if (k % 2 == 1) begin
        check($sformatf("fetch%0d_strb", (k - 1) / 2), 32'(strb_a), 32'(V_NONE));
        check($sformatf("fetch%0d_opnd", (k - 1) / 2), 32'(bus_a.o_OPERAND), 32'd0);
        check($sformatf("fetch%0d_pc",   (k - 1) / 2), 32'(bus_a.o_PROG_ADDR), 32'((k - 1) / 2));
        check($sformatf("fetch%0d_cnt",  (k - 1) / 2), 32'(bus_a.o_INSTR_CNT), 32'((k - 1) / 2));
      end else begin
        check($sformatf("exec%0d_strb", k / 2 - 1), 32'(strb_a), 32'(exp_strb[k / 2 - 1]));
        check($sformatf("exec%0d_opnd", k / 2 - 1), 32'(bus_a.o_OPERAND), 32'd12);
      end
      if (k < 19) tick();
    end

    // ---------------- asynchronous reset mid-EXEC of ADD ----------------
    mem_a[0] = ins(LDI, 11'd1);
    mem_a[1] = ins(ADD, 11'd10);
    bus_a.i_start = 1'b1;
    tick();
    bus_a.i_start = 1'b0;
    tick();
    tick();
    tick();
    check("arst_pre_strb", 32'(strb_a), 32'(V_ADD));
    check("arst_pre_acc",  32'(acc), 32'd1);
    #2 i_reset = 1'b1;
    #1;
    check("arst_strb", 32'(strb_a), 32'(V_NONE));
    check("arst_busy", 32'(bus_a.o_BUSY), 32'd0);
    check("arst_pc",   32'(bus_a.o_PROG_ADDR), 32'd0);
    check("arst_cnt",  32'(bus_a.o_INSTR_CNT), 32'd0);
    check("arst_opnd", 32'(bus_a.o_OPERAND), 32'd0);
    tick();
    check("arst_acc_kept", 32'(acc), 32'd1);
    #2 i_reset = 1'b0;
    tick();
    check("arst_idle", 32'(bus_a.o_BUSY), 32'd0);

    // ---------------- narrow DUT: PC wrap 7 -> 0, HLT at 0, count saturates ----------------
    bus_b.i_start = 1'b1;
    tick();
    bus_b.i_start = 1'b0;
    for (int k = 1; k <= 19; k++) begin
      if (k == 3) mem_b[0] = 8'h00;
      if (k == 5) bus_b.i_start = 1'b1;
      if (k == 6) bus_b.i_start = 1'b0;
      case (k)
        7:  check("wrap_cnt_sat",  32'(bus_b.o_INSTR_CNT), 32'd3);
        9:  check("wrap_cnt_hold", 32'(bus_b.o_INSTR_CNT), 32'd3);
        16: check("wrap_pc7",      32'(bus_b.o_PROG_ADDR), 32'd7);
        17: begin
          check("wrap_pc0",   32'(bus_b.o_PROG_ADDR), 32'd0);
          check("wrap_busy",  32'(bus_b.o_BUSY), 32'd1);
        end
        18: check("wrap_halt_early", 32'(bus_b.o_HALT), 32'd0);
        19: begin
          check("wrap_halt",    32'(bus_b.o_HALT), 32'd1);
          check("wrap_halt_pc", 32'(bus_b.o_PROG_ADDR), 32'd0);
          check("wrap_cnt",     32'(bus_b.o_INSTR_CNT), 32'd3);
        end
        default: ;
      endcase
      if (k < 19) tick();
    end

    // ---------------- narrow DUT: restart from HALT, 5 NOPs + HLT ----------------
    for (int i = 0; i < 5; i++) mem_b[i] = 8'hF8;
    mem_b[5] = 8'h00;
    bus_b.i_start = 1'b1;
    tick();
    bus_b.i_start = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      case (k)
        1: begin
          check("restart_pc",  32'(bus_b.o_PROG_ADDR), 32'd0);
          check("restart_cnt", 32'(bus_b.o_INSTR_CNT), 32'd0);
          check("restart_busy", 32'(bus_b.o_BUSY), 32'd1);
        end
        3:  check("sat_cnt1", 32'(bus_b.o_INSTR_CNT), 32'd1);
        12: begin
          check("sat_hlt_strb",   32'(strb_b), 32'(V_NONE));
          check("sat_halt_early", 32'(bus_b.o_HALT), 32'd0);
        end
        13: begin
          check("sat_halt", 32'(bus_b.o_HALT), 32'd1);
          check("sat_pc",   32'(bus_b.o_PROG_ADDR), 32'd5);
          check("sat_cnt",  32'(bus_b.o_INSTR_CNT), 32'd3);
        end
        default: ;
      endcase
      if (k < 13) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
